id_branch_front: RTL and testbench

- Consumer end of the fetch-to-decode interface.
- Latches the fetch bus into the IF/ID pipeline register and owns the valid/allowin handshake toward fetch.
- Decodes MIPS branch and jump instructions, resolves them in ID, and drives br_bus back to fetch: delay-slot flag, load-use stall, taken flag and target.
- Forwards the latched bundle to EXE under the same valid/allowin protocol.

---
 rtl/id_branch_front_if.sv | 21 ++
 rtl/id_branch_front.sv | 142 ++++++++++++++
 tb/tb_id_branch_front.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_branch_front_if.sv
// Pipeline link between two stages: the producer drives valid/bus and the
// consumer answers with allowin.
interface id_branch_front_if #(
    parameter int WD = 71
);
    logic          valid;
    logic          allowin;
    logic [WD-1:0] bus;

    modport master (
        output valid,
        output bus,
        input  allowin
    );

    modport slave (
        input  valid,
        input  bus,
        output allowin
    );
endinterface

// File: rtl/id_branch_front.sv
// ID-stage front end: IF/ID register, fetch/EXE handshake, and in-ID
// resolution of MIPS branches and jumps returned to fetch over br_bus.
module id_branch_front #(
    parameter int FS_TO_DS_BUS_WD = 71,
    parameter int BR_BUS_WD       = 35,
    parameter int DS_TO_ES_BUS_WD = 71
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    id_branch_front_if.slave     fs_link,
    id_branch_front_if.master    es_link,
    output logic [4:0]           rs_addr,
    output logic [4:0]           rt_addr,
    input  logic [31:0]          rs_value,
    input  logic [31:0]          rt_value,
    input  logic                 es_valid,
    input  logic                 es_is_load,
    input  logic [4:0]           es_dest,
    output logic [BR_BUS_WD-1:0] br_bus
);

    logic                       ds_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_bus;
    logic [FS_TO_DS_BUS_WD-1:0] fs_bus;
    logic                       ds_allowin;
    logic                       ds_ready_go;

    logic [31:0] inst;
    logic [31:0] pc;
    logic        ex;
    logic [5:0]  op;
    logic [4:0]  rt_field;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic is_beq, is_bne, is_blez, is_bgtz, is_regimm, is_bgez, is_bltz;
    logic is_j, is_jr, dec_hit, is_branch, use_rs, use_rt;
    logic rs_eq_rt, rs_neg, rs_zero;
    logic cond_true;

    logic [31:0] seq_pc;
    logic [31:0] br_offset;
    logic [31:0] b_target;
    logic [31:0] j_target;
    logic [31:0] calc_target;

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;

    assign fs_bus   = fs_link.bus;
    assign inst     = ds_bus[63:32];
    assign pc       = ds_bus[31:0];
    assign ex       = ds_bus[70];
    assign op       = inst[31:26];
    assign rt_field = inst[20:16];
    assign funct    = inst[5:0];
    assign imm      = inst[15:0];
    assign rs_addr  = inst[25:21];
    assign rt_addr  = inst[20:16];

    assign is_beq    = (op == 6'b000100);
    assign is_bne    = (op == 6'b000101);
    assign is_blez   = (op == 6'b000110);
    assign is_bgtz   = (op == 6'b000111);
    assign is_regimm = (op == 6'b000001);
    assign is_bgez   = is_regimm && (rt_field == 5'b00001 || rt_field == 5'b10001);
    assign is_bltz   = is_regimm && (rt_field == 5'b00000 || rt_field == 5'b10000);
    assign is_j      = (op == 6'b000010) || (op == 6'b000011);
    assign is_jr     = (op == 6'b000000) && (funct == 6'b001000 || funct == 6'b001001);

    assign dec_hit = is_beq | is_bne | is_blez | is_bgtz | is_bgez | is_bltz | is_j | is_jr;

    // A bundle that already carries a fetch exception must never redirect fetch.
    assign is_branch = dec_hit && ds_valid && !ex;

    assign use_rs = is_beq | is_bne | is_blez | is_bgtz | is_bgez | is_bltz | is_jr;
    assign use_rt = is_beq | is_bne;

    assign rs_eq_rt = (rs_value == rt_value);
    assign rs_neg   = rs_value[31];
    assign rs_zero  = (rs_value == 32'd0);

    assign seq_pc    = pc + 32'd4;
    assign br_offset = {{14{imm[15]}}, imm, 2'b00};
    assign b_target  = seq_pc + br_offset;
    assign j_target  = {seq_pc[31:28], inst[25:0], 2'b00};

    always_comb begin
        cond_true   = 1'b0;
        calc_target = b_target;
        if (is_beq) begin
            cond_true = rs_eq_rt;
        end else if (is_bne) begin
            cond_true = !rs_eq_rt;
        end else if (is_blez) begin
            cond_true = rs_neg || rs_zero;
        end else if (is_bgtz) begin
            cond_true = !rs_neg && !rs_zero;
        end else if (is_bgez) begin
            cond_true = !rs_neg;
        end else if (is_bltz) begin
            cond_true = rs_neg;
        end else if (is_j) begin
            cond_true   = 1'b1;
            calc_target = j_target;
        end else if (is_jr) begin
            cond_true   = 1'b1;
            calc_target = rs_value;
        end
    end

    // Load result is not forwardable yet; $0 is hard-wired and never waits.
    assign br_stall = is_branch && es_valid && es_is_load && (es_dest != 5'd0) &&
                      ((use_rs && es_dest == rs_addr) || (use_rt && es_dest == rt_addr));

    assign br_taken  = is_branch && cond_true && !br_stall && !flush;
    assign br_target = br_taken ? calc_target : 32'd0;
    assign br_bus    = {is_branch, br_stall, br_taken, br_target};

    assign ds_ready_go    = !br_stall;
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_link.allowin);
    assign fs_link.allowin = ds_allowin;
    assign es_link.valid  = ds_valid && ds_ready_go && !flush;
    assign es_link.bus    = ds_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_bus   <= '0;
        end else if (flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_link.valid;
            if (fs_link.valid) begin
                ds_bus <= fs_bus;
            end
        end
    end

endmodule

// File: tb/tb_id_branch_front.sv
// Directed bench for id_branch_front: per-cycle output expectations and EXE
// deliveries are queued by the driver and checked by an independent monitor.
module tb_id_branch_front;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        es_valid;
    logic        es_is_load;
    logic [4:0]  es_dest;
    logic [34:0] br_bus;

    id_branch_front_if #(.WD(71)) fs_to_ds ();
    id_branch_front_if #(.WD(71)) ds_to_es ();

    id_branch_front dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fs_link    (fs_to_ds),
        .es_link    (ds_to_es),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_value   (rs_value),
        .rt_value   (rt_value),
        .es_valid   (es_valid),
        .es_is_load (es_is_load),
        .es_dest    (es_dest),
        .br_bus     (br_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        allowin;
        logic        tes_valid;
        logic        chk_addr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [34:0] bb;
        logic [34:0] mask;
    } exp_t;

    exp_t        chk_q[$];
    logic [70:0] exe_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [34:0] ALL = {35{1'b1}};

    function automatic logic [70:0] mk(input logic exb, input logic [4:0] code,
                                       input logic bd, input logic [31:0] ins,
                                       input logic [31:0] pcv);
        return {exb, code, bd, ins, pcv};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic alw, input logic tv, input logic ca,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [34:0] bb, input logic [34:0] mask);
        exp_t e;
        e.allowin   = alw;
        e.tes_valid = tv;
        e.chk_addr  = ca;
        e.ra        = ra;
        e.rb        = rb;
        e.bb        = bb;
        e.mask      = mask;
        chk_q.push_back(e);
    endtask

    task automatic fetch(input logic v, input logic [70:0] b);
        fs_to_ds.valid = v;
        fs_to_ds.bus   = b;
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [70:0] eb;
        if (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            n_vec++;
            if (fs_to_ds.allowin !== e.allowin || ds_to_es.valid !== e.tes_valid ||
                (br_bus & e.mask) !== (e.bb & e.mask) ||
                (e.chk_addr && (rs_addr !== e.ra || rt_addr !== e.rb))) begin
                n_err++;
                $display("FAIL outputs @%0t: got allowin=%b es_valid=%b rs=%0d rt=%0d br_bus=%h, want allowin=%b es_valid=%b rs=%0d rt=%0d br_bus=%h (mask %h)",
                         $time, fs_to_ds.allowin, ds_to_es.valid, rs_addr, rt_addr, br_bus,
                         e.allowin, e.tes_valid, e.ra, e.rb, e.bb, e.mask);
            end
        end
        if (!reset && ds_to_es.valid === 1'b1 && ds_to_es.allowin === 1'b1) begin
            n_vec++;
            if (exe_q.size() == 0) begin
                n_err++;
                $display("FAIL exe_delivery @%0t: got unexpected bundle %h, want none", $time, ds_to_es.bus);
            end else begin
                eb = exe_q.pop_front();
                if (ds_to_es.bus !== eb) begin
                    n_err++;
                    $display("FAIL exe_bundle @%0t: got %h, want %h", $time, ds_to_es.bus, eb);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [70:0] b_beq, b_jr, b_j, b_exc, b_beq0, b_bne, b_bltz;
        b_beq  = mk(1'b0, 5'd0, 1'b0, 32'h10220003, 32'hBFC00000);
        b_jr   = mk(1'b0, 5'd0, 1'b0, 32'h03E00008, 32'hBFC00100);
        b_j    = mk(1'b0, 5'd0, 1'b0, 32'h08000040, 32'hBFC00104);
        b_exc  = mk(1'b1, 5'd4, 1'b0, 32'h10220003, 32'hBFC00200);
        b_beq0 = mk(1'b0, 5'd0, 1'b0, 32'h10000002, 32'hBFC00300);
        b_bne  = mk(1'b0, 5'd0, 1'b0, 32'h14640005, 32'hBFC00310);
        b_bltz = mk(1'b0, 5'd0, 1'b0, 32'h04A0FFFC, 32'hBFC00400);

        reset = 1'b1; flush = 1'b0;
        fetch(1'b0, '0);
        ds_to_es.allowin = 1'b1;
        rs_value = 32'd0; rt_value = 32'd0;
        es_valid = 1'b0; es_is_load = 1'b0; es_dest = 5'd0;
        tick(); tick();
        reset = 1'b0;
        expect_out(1, 0, 1, 0, 0, 35'h0, ALL);

        // beq taken, no hazard
        tick(); fetch(1'b1, b_beq);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0); rs_value = 32'd5; rt_value = 32'd5;
        expect_out(1, 1, 1, 5'd1, 5'd2, 35'h5_BFC0_0010, ALL);
        exe_q.push_back(b_beq);

        // beq load-use stall on rt, then release into a blocked EXE
        tick(); fetch(1'b1, b_beq);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0); es_valid = 1'b1; es_is_load = 1'b1; es_dest = 5'd2;
        expect_out(0, 0, 1, 5'd1, 5'd2, 35'h6_0000_0000, ALL);
        tick();
        expect_out(0, 0, 1, 5'd1, 5'd2, 35'h6_0000_0000, ALL);
        tick(); es_valid = 1'b0; ds_to_es.allowin = 1'b0;
        expect_out(0, 1, 1, 5'd1, 5'd2, 35'h5_BFC0_0010, ALL);
        tick(); ds_to_es.allowin = 1'b1;
        expect_out(1, 1, 1, 5'd1, 5'd2, 35'h5_BFC0_0010, ALL);
        exe_q.push_back(b_beq);

        // jr then j back-to-back
        tick(); fetch(1'b1, b_jr);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b1, b_j); rs_value = 32'h80001234;
        expect_out(1, 1, 1, 5'd31, 5'd0, 35'h5_8000_1234, ALL);
        exe_q.push_back(b_jr);
        tick(); fetch(1'b0, '0);
        expect_out(1, 1, 1, 5'd0, 5'd0, 35'h5_B000_0100, ALL);
        exe_q.push_back(b_j);

        // fetch-exception bundle with a beq encoding is not a branch
        tick(); fetch(1'b1, b_exc); rs_value = 32'd5; rt_value = 32'd5;
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0);
        expect_out(1, 1, 1, 5'd1, 5'd2, 35'h0, ALL);
        exe_q.push_back(b_exc);

        // beq $0,$0 with a load to $0 in EXE must not stall
        tick(); fetch(1'b1, b_beq0);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0); es_valid = 1'b1; es_is_load = 1'b1; es_dest = 5'd0;
        expect_out(1, 1, 1, 5'd0, 5'd0, 35'h5_BFC0_030C, ALL);
        exe_q.push_back(b_beq0);

        // bne with equal operands: branch seen, not taken
        tick(); es_valid = 1'b0; fetch(1'b1, b_bne);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0); rs_value = 32'd7; rt_value = 32'd7;
        expect_out(1, 1, 1, 5'd3, 5'd4, 35'h4_0000_0000, ALL);
        exe_q.push_back(b_bne);

        // bltz taken with a negative offset
        tick(); fetch(1'b1, b_bltz);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0); rs_value = 32'hFFFFFFFF;
        expect_out(1, 1, 1, 5'd5, 5'd0, 35'h5_BFC0_03F4, ALL);
        exe_q.push_back(b_bltz);

        // stalled bltz killed by flush
        tick(); fetch(1'b1, b_bltz);
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); fetch(1'b0, '0); es_valid = 1'b1; es_is_load = 1'b1; es_dest = 5'd5;
        expect_out(0, 0, 1, 5'd5, 5'd0, 35'h6_0000_0000, ALL);
        tick(); flush = 1'b1;
        expect_out(0, 0, 1, 5'd5, 5'd0, 35'h4_0000_0000, ~(35'h1 << 33));
        tick(); flush = 1'b0;
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);
        tick(); es_valid = 1'b0; es_is_load = 1'b0;
        expect_out(1, 0, 0, 0, 0, 35'h0, ALL);

        tick(); tick(); tick();
        n_vec++;
        if (exe_q.size() != 0 || chk_q.size() != 0) begin
            n_err++;
            $display("FAIL queues_drained: got exe_q=%0d chk_q=%0d pending, want 0", exe_q.size(), chk_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
